// File: rtl/fft_stream_sink.sv
// Ping-pong frame sink: captures 16-point FFT frames into two banks and streams
// them out one point per handshake, optionally in bit-reversed index order.
module fft_stream_sink #(
  parameter bit BIT_REV = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_re,
  output logic [15:0] out_im,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        overrun,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned N_PTS  = 16;
  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_IDX  = 4;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t             st, st_n;
  logic               cur, cur_n;
  logic [W_IDX-1:0]   cnt, cnt_n;
  logic [1:0]         full, full_n, full_rel;
  logic               hs, rel, cap, cap_bank, drop;
  logic [W_IDX-1:0]   ridx_n;
  logic [W_WORD-1:0]  word_n;
  logic [W_WORD-1:0]  words [N_PTS];
  logic [W_WORD-1:0]  mem   [2][N_PTS];

  function automatic logic [W_IDX-1:0] rev4(input logic [W_IDX-1:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  assign words[0]  = fft_d0;
  assign words[1]  = fft_d1;
  assign words[2]  = fft_d2;
  assign words[3]  = fft_d3;
  assign words[4]  = fft_d4;
  assign words[5]  = fft_d5;
  assign words[6]  = fft_d6;
  assign words[7]  = fft_d7;
  assign words[8]  = fft_d8;
  assign words[9]  = fft_d9;
  assign words[10] = fft_d10;
  assign words[11] = fft_d11;
  assign words[12] = fft_d12;
  assign words[13] = fft_d13;
  assign words[14] = fft_d14;
  assign words[15] = fft_d15;

  // Bank bookkeeping, streamer next state and look-ahead of the next point.
  always_comb begin
    hs       = out_valid & out_ready;
    rel      = hs && (cnt == W_IDX'(N_PTS - 1));
    full_rel = full;
    if (rel) full_rel[cur] = 1'b0;
    cap      = fft_valid && (full_rel != 2'b11);
    // a released bank is reused first; otherwise the lowest free bank
    cap_bank = rel ? cur : full_rel[0];
    drop     = fft_valid && !cap;
    full_n   = full_rel;
    if (cap) full_n[cap_bank] = 1'b1;

    st_n  = st;
    cur_n = cur;
    cnt_n = cnt;
    case (st)
      IDLE: begin
        if (cap) begin
          st_n  = STREAM;
          cur_n = cap_bank;
          cnt_n = '0;
        end
      end
      STREAM: begin
        if (hs) begin
          cnt_n = cnt + W_IDX'(1);
          if (rel) begin
            if (full_rel[~cur]) cur_n = ~cur;
            else if (cap)       cur_n = cap_bank;
            else                st_n  = IDLE;
          end
        end
      end
      default: st_n = IDLE;
    endcase

    ridx_n = BIT_REV ? rev4(cnt_n) : cnt_n;
    word_n = (cap && (cap_bank == cur_n)) ? words[ridx_n] : mem[cur_n][ridx_n];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      cur  <= 1'b0;
      cnt  <= '0;
      full <= 2'b00;
    end else begin
      st   <= st_n;
      cur  <= cur_n;
      cnt  <= cnt_n;
      full <= full_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      out_valid <= (st_n == STREAM);
      out_re    <= word_n[31:16];
      out_im    <= word_n[15:0];
      out_idx   <= ridx_n;
      out_last  <= (st_n == STREAM) && (cnt_n == W_IDX'(N_PTS - 1));
      if (drop) overrun <= 1'b1;
      if (rel)  frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Frame storage needs no reset: bank FULL flags gate every read.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < N_PTS; k++) mem[cap_bank][k] <= words[k];
    end
  end

endmodule

// File: tb/tb_fft_stream_sink.sv
// Scoreboard bench for fft_stream_sink: one instance per BIT_REV setting,
// sharing stimulus; a negedge monitor pops expected points on each handshake.
module tb_fft_stream_sink;

  typedef struct packed {
    logic        last;
    logic [3:0]  idx;
    logic [15:0] re;
    logic [15:0] im;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fft_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] d [16];

  logic        o0_valid, o0_last, o0_ovr, o1_valid, o1_last, o1_ovr;
  logic [15:0] o0_re, o0_im, o1_re, o1_im;
  logic [3:0]  o0_idx, o1_idx;
  logic [7:0]  o0_fc, o1_fc;

  int   nvec = 0;
  int   nerr = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic stalled [2];
  exp_t held    [2];
  int   rev_seq [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always #5 clk = ~clk;

  fft_stream_sink #(.BIT_REV(1'b0)) u0 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .out_ready(out_ready), .out_valid(o0_valid), .out_re(o0_re), .out_im(o0_im),
    .out_idx(o0_idx), .out_last(o0_last), .overrun(o0_ovr), .frame_cnt(o0_fc)
  );

  fft_stream_sink #(.BIT_REV(1'b1)) u1 (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
    .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
    .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
    .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
    .out_ready(out_ready), .out_valid(o1_valid), .out_re(o1_re), .out_im(o1_im),
    .out_idx(o1_idx), .out_last(o1_last), .overrun(o1_ovr), .frame_cnt(o1_fc)
  );

  // Frame f, point k: real = k*0x100 + f*0x1000, imag = -k*0x100.
  function automatic logic [31:0] word(input int f, input int k);
    logic [15:0] re, im;
    re = 16'((k << 8) + (f << 12));
    im = 16'(-(k << 8));
    return {re, im};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int f);
    for (int i = 0; i < 16; i++) begin
      q0.push_back({i == 15, 4'(i), word(f, i)});
      q1.push_back({i == 15, 4'(rev_seq[i]), word(f, rev_seq[i])});
    end
  endtask

  task automatic send_frame(input int f, input bit expect_out);
    for (int k = 0; k < 16; k++) d[k] = word(f, k);
    fft_valid = 1'b1;
    if (expect_out) push_frame(f);
    tick();
    fft_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_remaining", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic mon(input int inst, input exp_t act, input logic v);
    exp_t e;
    if (stalled[inst]) begin
      nvec++;
      if (act !== held[inst]) begin
        nerr++;
        $display("FAIL stall_hold inst%0d: got %h want %h", inst, act, held[inst]);
      end
    end
    if (v && out_ready) begin
      stalled[inst] = 1'b0;
      nvec++;
      if ((inst == 0 ? q0.size() : q1.size()) == 0) begin
        nerr++;
        $display("FAIL unexpected_point inst%0d: got %h want no point", inst, act);
      end else begin
        e = (inst == 0) ? q0.pop_front() : q1.pop_front();
        if (act !== e) begin
          nerr++;
          $display("FAIL point inst%0d: got %h want %h", inst, act, e);
        end
      end
    end else if (v) begin
      stalled[inst] = 1'b1;
      held[inst]    = act;
    end else begin
      stalled[inst] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      stalled[0] = 1'b0;
      stalled[1] = 1'b0;
    end else begin
      mon(0, {o0_last, o0_idx, o0_re, o0_im}, o0_valid);
      mon(1, {o1_last, o1_idx, o1_re, o1_im}, o1_valid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit any_valid;
    for (int k = 0; k < 16; k++) d[k] = '0;
    stalled[0] = 1'b0;
    stalled[1] = 1'b0;
    tick();
    tick();
    chk("reset_out0", {o0_valid, o0_last, o0_idx, o0_re, o0_im, o0_ovr, o0_fc}, 64'd0);
    chk("reset_out1", {o1_valid, o1_last, o1_idx, o1_re, o1_im, o1_ovr, o1_fc}, 64'd0);
    rst = 1'b1;
    tick();

    // single frame, continuous ready: 16 back-to-back points one cycle after capture
    out_ready = 1'b1;
    send_frame(0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("t1_valid_run", {o0_valid, o1_valid}, 64'h3);
      tick();
    end
    @(negedge clk);
    chk("t1_idle_after", {o0_valid, o1_valid}, 64'h0);
    chk("t1_frame_cnt", {o0_fc, o1_fc}, 64'h0101);

    // toggled ready, then a 5-cycle stall on index 7
    tick();
    out_ready = 1'b0;
    send_frame(1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      out_ready = (i % 2 == 0);
      tick();
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t2_stall_idx", {o0_idx, o1_idx}, 64'h7e);
    tick();
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b1;
    wait_drain(40);
    chk("t2_frame_cnt", {o0_fc, o1_fc}, 64'h0202);

    // three frames with ready low: two buffered, third dropped
    out_ready = 1'b0;
    tick();
    send_frame(2, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    send_frame(3, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    send_frame(4, 1'b0);
    @(negedge clk);
    chk("t3_overrun", {o0_ovr, o1_ovr}, 64'h3);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t3_no_gap", {o0_valid, o1_valid}, 64'h3);
      tick();
    end
    @(negedge clk);
    chk("t3_idle_after", {o0_valid, o1_valid}, 64'h0);
    chk("t3_frame_cnt", {o0_fc, o1_fc}, 64'h0404);
    chk("t3_queue_empty", 64'(q0.size() + q1.size()), 64'd0);

    // reset mid-frame with a second frame queued
    tick();
    out_ready = 1'b0;
    send_frame(5, 1'b1);
    send_frame(6, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_pre_rst_idx", 64'(o0_idx), 64'd5);
    #1;
    rst = 1'b0;
    #1;
    chk("t4_rst_out0", {o0_valid, o0_last, o0_idx, o0_re, o0_im, o0_ovr, o0_fc}, 64'd0);
    chk("t4_rst_out1", {o1_valid, o1_last, o1_idx, o1_re, o1_im, o1_ovr, o1_fc}, 64'd0);
    q0.delete();
    q1.delete();
    tick();
    tick();
    rst = 1'b1;
    any_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      any_valid = any_valid | o0_valid | o1_valid;
      tick();
    end
    chk("t4_no_resume", 64'(any_valid), 64'd0);

    // both banks full; new frame arrives on the final handshake
    out_ready = 1'b0;
    send_frame(7, 1'b1);
    send_frame(8, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    send_frame(9, 1'b1);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t5_no_gap", {o0_valid, o1_valid}, 64'h3);
      tick();
    end
    @(negedge clk);
    chk("t5_idle_after", {o0_valid, o1_valid}, 64'h0);
    chk("t5_overrun", {o0_ovr, o1_ovr}, 64'h0);
    chk("t5_frame_cnt", {o0_fc, o1_fc}, 64'h0303);
    chk("t5_queue_empty", 64'(q0.size() + q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fft_stream_sink.md
FFT_STREAM_SINK -- requirements
Module: fft_stream_sink

Interface
REQ-001 The block SHALL have parameter BIT_REV, default 0: 0 emits points in index order 0..15; 1 emits them in 4-bit bit-reversed order (0,8,4,12,...,15).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port fft_valid, input, 1 bit: one-cycle pulse marking a 16-point frame on fft_d0..fft_d15.
REQ-005 The block SHALL have ports fft_d0..fft_d15, input, 32 bits each: [31:16] real, [15:0] imag, both signed 8.8.
REQ-006 The block SHALL have port out_ready, input, 1 bit: downstream accepts the current point.
REQ-007 The block SHALL have port out_valid, output, 1 bit: a point is presented.
REQ-008 The block SHALL have port out_re, output, 16 bits: signed real part.
REQ-009 The block SHALL have port out_im, output, 16 bits: signed imag part.
REQ-010 The block SHALL have port out_idx, output, 4 bits: frequency index of the presented point.
REQ-011 The block SHALL have port out_last, output, 1 bit: high with the 16th point of a frame.
REQ-012 The block SHALL have port overrun, output, 1 bit: sticky, a frame was dropped.
REQ-013 The block SHALL have port frame_cnt, output, 8 bits: count of fully emitted frames, wraps 255->0.

Function
REQ-014 The block SHALL hold two 16x32 frame banks (ping-pong), each marked FULL or FREE.
REQ-015 On fft_valid with at least one bank FREE, the block SHALL capture all 16 words into a FREE bank (lowest-numbered FREE bank if both FREE) and mark it FULL.
REQ-016 On fft_valid with both banks FULL and no release this cycle, the block SHALL drop the frame, set overrun, and leave both banks unchanged.
REQ-017 A release (final handshake) and fft_valid in the same cycle SHALL capture the new frame into the released bank; no drop, overrun unchanged.
REQ-018 The streamer FSM SHALL have states IDLE and STREAM; IDLE->STREAM when any bank is FULL, selecting the older FULL bank; STREAM->IDLE after the 16th handshake if no other bank is FULL, else STREAM continues on the other bank with no gap cycle.
REQ-019 Latency SHALL be one cycle: fft_valid in cycle N with streamer IDLE gives out_valid=1 in cycle N+1 with the first point of the emission order.
REQ-020 A handshake SHALL occur when out_valid and out_ready are both 1; the 4-bit point counter SHALL then advance by one.
REQ-021 While out_valid=1 and out_ready=0, out_re, out_im, out_idx and out_last SHALL hold stable.
REQ-022 out_idx SHALL equal the counter when BIT_REV=0 and bitreverse(counter) when BIT_REV=1; out_re/out_im SHALL be bits [31:16]/[15:0] of word out_idx, unmodified.
REQ-023 out_last SHALL be 1 exactly when the counter is 15 and out_valid is 1.
REQ-024 On the 16th handshake the bank SHALL become FREE, the counter SHALL wrap to 0, and frame_cnt SHALL increment.
REQ-025 out_valid SHALL be 0 in IDLE; outputs are don't-care only while out_valid=0, except overrun and frame_cnt.

Reset
REQ-026 While rst=0, the block SHALL immediately force out_valid=0, out_last=0, out_idx=0, out_re=0, out_im=0, overrun=0, frame_cnt=0, both banks FREE, FSM=IDLE, counter=0.
REQ-027 Reset asserted mid-frame SHALL discard the partially emitted frame and any queued frame; no emission SHALL resume after release.
REQ-028 overrun SHALL clear only by reset.

Verification
REQ-029 Single frame, fft_dk={k*0x0100, -k*0x0100}, out_ready=1, BIT_REV=0 -> out_valid 1 cycle after fft_valid, 16 consecutive points idx 0..15, out_re=k<<8, out_last on idx 15, frame_cnt=1.
REQ-030 Same frame with BIT_REV=1 -> idx sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with matching data.
REQ-031 out_ready toggled 1010..., then held 0 for 5 cycles at idx 7 -> outputs stable during stall, 16 points emitted, none duplicated or lost.
REQ-032 Three fft_valid pulses 4 cycles apart with out_ready=0 -> frames 1,2 buffered, frame 3 dropped, overrun=1; after out_ready=1, 32 points of frames 1 then 2 back-to-back with no gap, frame_cnt=2.
REQ-033 Both banks FULL, fft_valid coincident with 16th handshake -> new frame emitted next, overrun stays 0.
REQ-034 rst pulsed low at idx 5 with second frame queued -> all outputs 0 immediately; no out_valid afterwards until a new fft_valid.
